// File: rtl/jump_physics_if.sv
// jump_physics_if
//   Frame-rate bus between the operation decoder / platform logic and the
//   vertical-motion engine.
//   master : drives update, operation, floor_y; observes the sprite state.
//   slave  : the engine; consumes the requests and drives yout, airborne,
//            landed and busy_op.
//   update    : one-cycle frame tick
//   operation : one-hot request (001 big jump, 010 small jump, 100 drop)
//   floor_y   : floor height under the sprite this frame
//   yout      : sprite height (larger is higher)
//   airborne  : sprite is in the air
//   landed    : one-cycle pulse on touchdown
//   busy_op   : a request is latched and not yet consumed
interface jump_physics_if #(
  parameter int Y_W = 7
) ();
  logic           update;
  logic [2:0]     operation;
  logic [Y_W-1:0] floor_y;
  logic [Y_W-1:0] yout;
  logic           airborne;
  logic           landed;
  logic           busy_op;

  modport master (
    output update, operation, floor_y,
    input  yout, airborne, landed, busy_op
  );

  modport slave (
    input  update, operation, floor_y,
    output yout, airborne, landed, busy_op
  );
endinterface

// File: rtl/jump_physics.sv
// jump_physics
//   Vertical-motion engine for the runner sprite. Integrates velocity and
//   gravity once per frame tick, tracks a per-frame floor height, clamps at
//   the ceiling, handles walk-off falls, drop-through and an optional
//   double jump.
//   clk   : single clock
//   reset : synchronous, active-low
//   bus   : jump_physics_if slave (update/operation/floor_y in,
//           yout/airborne/landed/busy_op out)
module jump_physics #(
  parameter int Y_W         = 7,
  parameter int Y_MAX       = 127,
  parameter int RESET_Y     = 20,
  parameter int BIG_V       = 9,
  parameter int SMALL_V     = 7,
  parameter int GRAVITY     = 1,
  parameter int VMAX_FALL   = 8,
  parameter int DOUBLE_JUMP = 0
) (
  input  logic          clk,
  input  logic          reset,
  jump_physics_if.slave bus
);

  localparam int V_W  = Y_W + 1;  // signed velocity width
  localparam int YS_W = Y_W + 2;  // signed working width for y + vel

  localparam logic signed [V_W-1:0]  BIG_VEL   = V_W'(BIG_V);
  localparam logic signed [V_W-1:0]  SMALL_VEL = V_W'(SMALL_V);
  localparam logic signed [V_W-1:0]  DROP_VEL  = V_W'(-1);
  localparam logic signed [V_W-1:0]  ZERO_VEL  = {V_W{1'b0}};
  localparam logic signed [V_W-1:0]  VMIN_VEL  = V_W'(-VMAX_FALL);
  localparam logic signed [YS_W-1:0] GRAV_S    = YS_W'(GRAVITY);
  localparam logic signed [YS_W-1:0] VMIN_S    = YS_W'(-VMAX_FALL);
  localparam logic signed [YS_W-1:0] YMAX_S    = YS_W'(Y_MAX);
  localparam logic [Y_W-1:0]         YMAX_U    = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]         RESET_Y_U = Y_W'(RESET_Y);
  localparam logic [2:0]             OP_NONE   = 3'b000;
  localparam logic [2:0]             OP_BIG    = 3'b001;
  localparam logic [2:0]             OP_SMALL  = 3'b010;
  localparam logic [2:0]             OP_DROP   = 3'b100;
  localparam logic                   DJ_EN     = (DOUBLE_JUMP != 0);

  typedef enum logic {GROUND = 1'b0, AIR = 1'b1} state_t;

  // State registers
  state_t                 state_r;
  logic [Y_W-1:0]         y_r;
  logic signed [V_W-1:0]  vel_r;
  logic [2:0]             pend_r;
  logic                   jumps_left_r;
  logic [Y_W-1:0]         drop_ref_r;
  logic                   drop_act_r;
  logic                   landed_r;

  // Next-state values
  state_t                 state_s;
  logic [Y_W-1:0]         y_s;
  logic signed [V_W-1:0]  vel_s;
  logic [2:0]             pend_s;
  logic                   jumps_left_s;
  logic [Y_W-1:0]         drop_ref_s;
  logic                   drop_act_s;
  logic                   landed_s;

  // Datapath helpers
  logic                   op_valid_s;
  logic                   jump_req_s;
  logic signed [V_W-1:0]  launch_vel_s;
  logic signed [YS_W-1:0] y_sum_s;
  logic signed [YS_W-1:0] vel_dec_s;
  logic signed [YS_W-1:0] floor_s;
  logic                   floor_ignored_s;
  logic                   land_ok_s;

  // Datapath: candidate height, decayed velocity and landing qualification
  always_comb begin
    op_valid_s   = (bus.operation == OP_BIG) || (bus.operation == OP_SMALL) ||
                   (bus.operation == OP_DROP);
    jump_req_s   = (pend_r == OP_BIG) || (pend_r == OP_SMALL);
    launch_vel_s = (pend_r == OP_BIG) ? BIG_VEL : SMALL_VEL;
    // Sign-extend velocity and zero-extend heights so y + vel cannot wrap
    y_sum_s      = $signed({2'b00, y_r}) + $signed({vel_r[V_W-1], vel_r});
    vel_dec_s    = $signed({vel_r[V_W-1], vel_r}) - GRAV_S;
    floor_s      = $signed({2'b00, bus.floor_y});
    // While dropping, any floor at or above the ledge we left is passed through
    floor_ignored_s = drop_act_r && (bus.floor_y >= drop_ref_r);
    land_ok_s    = (vel_r[V_W-1] || (vel_r == ZERO_VEL)) &&
                   (y_sum_s <= floor_s) && !floor_ignored_s;
  end

  // Next-state logic: request latch plus per-tick motion
  always_comb begin
    state_s      = state_r;
    y_s          = y_r;
    vel_s        = vel_r;
    pend_s       = pend_r;
    jumps_left_s = jumps_left_r;
    drop_ref_s   = drop_ref_r;
    drop_act_s   = drop_act_r;
    landed_s     = 1'b0;

    // First valid request wins; a tick consumes whatever is pending
    if ((pend_r == OP_NONE) && op_valid_s) begin
      pend_s = bus.operation;
    end else if (bus.update) begin
      pend_s = OP_NONE;
    end else begin
      pend_s = pend_r;
    end

    if (bus.update) begin
      case (state_r)
        GROUND: begin
          if (jump_req_s) begin
            vel_s        = launch_vel_s;
            state_s      = AIR;
            jumps_left_s = DJ_EN;
          end else if (pend_r == OP_DROP) begin
            vel_s      = DROP_VEL;
            drop_ref_s = y_r;
            drop_act_s = 1'b1;
            state_s    = AIR;
          end else if (bus.floor_y < y_r) begin
            // Walked off a ledge: start falling from rest
            vel_s   = ZERO_VEL;
            state_s = AIR;
          end else begin
            y_s = bus.floor_y;
          end
        end
        AIR: begin
          if (jump_req_s && jumps_left_r) begin
            vel_s        = launch_vel_s;
            jumps_left_s = 1'b0;
          end else begin
            vel_s = (vel_dec_s < VMIN_S) ? VMIN_VEL : vel_dec_s[V_W-1:0];
            if (y_sum_s[YS_W-1]) begin
              // Fell below zero: touch down at 0 even mid-drop
              y_s        = {Y_W{1'b0}};
              vel_s      = ZERO_VEL;
              state_s    = GROUND;
              landed_s   = 1'b1;
              drop_act_s = 1'b0;
            end else if (land_ok_s) begin
              y_s        = bus.floor_y;
              vel_s      = ZERO_VEL;
              state_s    = GROUND;
              landed_s   = 1'b1;
              drop_act_s = 1'b0;
            end else if (y_sum_s > YMAX_S) begin
              y_s   = YMAX_U;
              vel_s = ZERO_VEL;
            end else begin
              y_s = y_sum_s[Y_W-1:0];
            end
          end
        end
        default: begin
          state_s = GROUND;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= GROUND;
      y_r          <= RESET_Y_U;
      vel_r        <= ZERO_VEL;
      pend_r       <= OP_NONE;
      jumps_left_r <= 1'b0;
      drop_ref_r   <= {Y_W{1'b0}};
      drop_act_r   <= 1'b0;
      landed_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      y_r          <= y_s;
      vel_r        <= vel_s;
      pend_r       <= pend_s;
      jumps_left_r <= jumps_left_s;
      drop_ref_r   <= drop_ref_s;
      drop_act_r   <= drop_act_s;
      landed_r     <= landed_s;
    end
  end

  assign bus.yout     = y_r;
  assign bus.airborne = (state_r == AIR);
  assign bus.landed   = landed_r;
  assign bus.busy_op  = (pend_r != OP_NONE);

endmodule

// File: tb/tb_jump_physics.sv
// tb_jump_physics
//   Drives two engines from one stimulus: dut0 with default parameters and
//   dut1 with the double jump enabled. A table of per-frame vectors covers
//   the jump arcs, ceiling, walk-off and drop-through; hand-written
//   sequences cover reset, request latency, request priority, the landed
//   pulse width, the double jump and reset mid-air.
module tb_jump_physics;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       upd = 1'b0;
  logic [2:0] op = 3'b000;
  logic [6:0] fl = 7'd20;

  int checks = 0;
  int fails  = 0;

  jump_physics_if #(.Y_W(7)) if0 ();
  jump_physics_if #(.Y_W(7)) if1 ();

  assign if0.update    = upd;
  assign if0.operation = op;
  assign if0.floor_y   = fl;
  assign if1.update    = upd;
  assign if1.operation = op;
  assign if1.floor_y   = fl;

  jump_physics #(.DOUBLE_JUMP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  jump_physics #(.DOUBLE_JUMP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [6:0] fl;
    logic [6:0] y;
    logic       air;
    logic       land;
  } vec_t;

  vec_t vecs[$];

  int big_seq[20]   = '{29, 37, 44, 50, 55, 59, 62, 64, 65, 65,
                        64, 62, 59, 55, 50, 44, 37, 29, 21, 20};
  int small_seq[15] = '{27, 33, 38, 42, 45, 47, 48, 48, 47, 45,
                        42, 38, 33, 27, 20};
  int walk_seq[7]   = '{60, 59, 57, 54, 50, 45, 40};
  int ceil_seq[6]   = '{127, 127, 126, 124, 121, 120};

  task automatic add(input logic [2:0] o, input logic [6:0] f,
                     input logic [6:0] y, input logic air, input logic land);
    vec_t v;
    v.op = o; v.fl = f; v.y = y; v.air = air; v.land = land;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: request cycle, then a tick with the given floor; returns at
  // the falling edge after the tick so outputs reflect it.
  task automatic frame(input logic [2:0] o, input logic [6:0] f);
    @(negedge clk); op = o; fl = f; upd = 1'b0;
    @(negedge clk); op = 3'b000; upd = 1'b1;
    @(negedge clk); upd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; upd = 1'b0; op = 3'b000; fl = 7'd20;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic chk_both(input string name, input int y0, input int y1,
                          input int a0, input int a1);
    chk({name, " dut0 y"},   int'(if0.yout), y0);
    chk({name, " dut1 y"},   int'(if1.yout), y1);
    chk({name, " dut0 air"}, int'(if0.airborne), a0);
    chk({name, " dut1 air"}, int'(if1.airborne), a1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: invalid codes, big jump, small jump, walk-off, drop, ceiling
    add(3'b011, 7'd20, 7'd20, 1'b0, 1'b0);
    add(3'b110, 7'd20, 7'd20, 1'b0, 1'b0);
    add(3'b001, 7'd20, 7'd20, 1'b1, 1'b0);
    foreach (big_seq[i]) add(3'b000, 7'd20, 7'(big_seq[i]), i != 19, i == 19);
    add(3'b010, 7'd20, 7'd20, 1'b1, 1'b0);
    foreach (small_seq[i]) add(3'b000, 7'd20, 7'(small_seq[i]), i != 14, i == 14);
    add(3'b000, 7'd60, 7'd60, 1'b0, 1'b0);
    add(3'b000, 7'd40, 7'd60, 1'b1, 1'b0);
    foreach (walk_seq[i]) add(3'b000, 7'd40, 7'(walk_seq[i]), i != 6, i == 6);
    add(3'b000, 7'd60, 7'd60, 1'b0, 1'b0);
    add(3'b100, 7'd60, 7'd60, 1'b1, 1'b0);
    add(3'b000, 7'd60, 7'd59, 1'b1, 1'b0);
    add(3'b000, 7'd60, 7'd57, 1'b1, 1'b0);
    add(3'b000, 7'd60, 7'd54, 1'b1, 1'b0);
    add(3'b000, 7'd30, 7'd50, 1'b1, 1'b0);
    add(3'b000, 7'd30, 7'd45, 1'b1, 1'b0);
    add(3'b000, 7'd30, 7'd39, 1'b1, 1'b0);
    add(3'b000, 7'd30, 7'd32, 1'b1, 1'b0);
    add(3'b000, 7'd30, 7'd30, 1'b0, 1'b1);
    add(3'b000, 7'd120, 7'd120, 1'b0, 1'b0);
    add(3'b001, 7'd120, 7'd120, 1'b1, 1'b0);
    foreach (ceil_seq[i]) add(3'b000, 7'd120, 7'(ceil_seq[i]), i != 5, i == 5);

    // Reset state
    do_reset();
    chk_both("reset", 20, 20, 0, 0);
    chk("reset dut0 landed", int'(if0.landed), 0);
    chk("reset dut0 busy",   int'(if0.busy_op), 0);
    chk("reset dut1 busy",   int'(if1.busy_op), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      frame(vecs[i].op, vecs[i].fl);
      chk($sformatf("vec%0d dut0 y", i),    int'(if0.yout),     int'(vecs[i].y));
      chk($sformatf("vec%0d dut0 air", i),  int'(if0.airborne), int'(vecs[i].air));
      chk($sformatf("vec%0d dut0 land", i), int'(if0.landed),   int'(vecs[i].land));
      chk($sformatf("vec%0d dut1 y", i),    int'(if1.yout),     int'(vecs[i].y));
      chk($sformatf("vec%0d dut1 air", i),  int'(if1.airborne), int'(vecs[i].air));
      chk($sformatf("vec%0d dut1 land", i), int'(if1.landed),   int'(vecs[i].land));
    end

    // Request on the same cycle as a tick is only used on the next tick
    do_reset();
    @(negedge clk); op = 3'b001; upd = 1'b1; fl = 7'd20;
    @(negedge clk); op = 3'b000; upd = 1'b0;
    chk_both("latency tick0", 20, 20, 0, 0);
    chk("latency busy", int'(if0.busy_op), 1);
    frame(3'b000, 7'd20);
    chk_both("latency tick1", 20, 20, 1, 1);
    chk("latency busy cleared", int'(if0.busy_op), 0);
    frame(3'b000, 7'd20);
    chk_both("latency tick2", 29, 29, 1, 1);

    // The first request wins; a later one before the tick is dropped
    do_reset();
    @(negedge clk); op = 3'b010; fl = 7'd20;
    @(negedge clk); op = 3'b001;
    @(negedge clk); op = 3'b000; upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    frame(3'b000, 7'd20);
    chk_both("first wins", 27, 27, 1, 1);

    // Short walk-off fall; landed must drop after one cycle
    do_reset();
    frame(3'b000, 7'd25);
    chk_both("track up", 25, 25, 0, 0);
    frame(3'b000, 7'd20);
    frame(3'b000, 7'd20);
    frame(3'b000, 7'd20);
    chk_both("short fall", 24, 24, 1, 1);
    frame(3'b000, 7'd20);
    frame(3'b000, 7'd20);
    chk_both("short land", 20, 20, 0, 0);
    chk("short land pulse", int'(if0.landed), 1);
    @(posedge clk); #1;
    chk("landed one cycle dut0", int'(if0.landed), 0);
    chk("landed one cycle dut1", int'(if1.landed), 0);

    // Double jump at the apex of a small jump
    do_reset();
    frame(3'b010, 7'd20);
    for (int i = 0; i < 7; i++) frame(3'b000, 7'd20);
    chk_both("apex", 48, 48, 1, 1);
    frame(3'b010, 7'd20);
    chk_both("dj launch", 48, 48, 1, 1);
    frame(3'b000, 7'd20);
    chk_both("dj rise", 47, 55, 1, 1);
    @(negedge clk); op = 3'b010;
    @(negedge clk); op = 3'b000;
    chk("third req busy dut0", int'(if0.busy_op), 1);
    chk("third req busy dut1", int'(if1.busy_op), 1);
    frame(3'b000, 7'd20);
    chk_both("third req ignored", 45, 61, 1, 1);
    chk("third busy clear dut0", int'(if0.busy_op), 0);
    chk("third busy clear dut1", int'(if1.busy_op), 0);

    // Reset mid-air wins over a simultaneous tick and request
    @(negedge clk); reset = 1'b0; upd = 1'b1; op = 3'b001;
    @(negedge clk); reset = 1'b1; upd = 1'b0; op = 3'b000;
    chk_both("midair reset", 20, 20, 0, 0);
    chk("midair reset busy", int'(if1.busy_op), 0);
    frame(3'b000, 7'd20);
    chk_both("after reset tick", 20, 20, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jump_physics.md
# jump_physics

Parametrised vertical-motion engine for the runner sprite. It replaces the fixed jump/drop tables with velocity-plus-gravity integration and a per-frame floor height supplied by the platform logic. It adds ceiling clamping, walk-off-ledge falls, drop-through and an optional double jump. It sits between the keyboard/operation decoder and the sprite renderer, and advances one step per frame `update` tick.

## Interface
- `Y_W`, default 7: width of height values.
- `Y_MAX`, default 127: ceiling height; y never exceeds it.
- `RESET_Y`, default 20: height after reset.
- `BIG_V`, default 9: launch velocity for a big jump.
- `SMALL_V`, default 7: launch velocity for a small jump.
- `GRAVITY`, default 1: velocity decrement per tick.
- `VMAX_FALL`, default 8: magnitude of the terminal (most negative) velocity.
- `DOUBLE_JUMP`, default 0: 1 allows one extra jump while airborne.
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low reset.
- `update`, in, 1: frame tick, one-cycle pulse.
- `operation`, in, 3: one-hot request; 001 big jump, 010 small jump, 100 drop; other codes are ignored.
- `floor_y`, in, Y_W: floor height under the sprite for the current frame.
- `yout`, out, Y_W: sprite height, larger is higher.
- `airborne`, out, 1: high in the AIR state.
- `landed`, out, 1: one-cycle pulse on touchdown.
- `busy_op`, out, 1: a request is pending and not yet consumed.

## Operation
- Registers:
  - `y` (Y_W).
  - `vel`, signed, width Y_W+1.
  - `state` ∈ {GROUND, AIR}.
  - `pend` (3 bits).
  - `jumps_left` (1 bit).
  - `drop_ref` (Y_W) and `drop_act` (1 bit).
- Request latch:
  - On any cycle with `pend`==0 and a valid `operation`, `pend` captures that code. Later requests are ignored until `pend` is cleared.
  - `pend` is cleared on the next `update` tick, whether or not the request is honoured.
- All motion happens only on cycles where `update`=1. Otherwise every register except `pend` holds.
- GROUND, on each tick:
  - `pend`=big or small: vel ← BIG_V or SMALL_V; go to AIR; jumps_left ← DOUBLE_JUMP. `y` does not move on this tick.
  - `pend`=drop: vel ← -1; drop_ref ← y; drop_act ← 1; go to AIR.
  - No request and `floor_y` < y (walked off a ledge): vel ← 0; go to AIR.
  - Otherwise y ← floor_y (tracks a rising platform).
- AIR, on each tick:
  - If `pend` is big/small and jumps_left=1: vel ← launch value; jumps_left ← 0; y is unchanged this tick.
  - Otherwise y_n = y + vel, computed signed at Y_W+2 bits. Then vel ← max(vel − GRAVITY, −VMAX_FALL).
  - Ceiling: if y_n > Y_MAX, then y ← Y_MAX and vel ← 0.
  - Landing: applies when vel ≤ 0, y_n ≤ floor_y, and (drop_act=0 or floor_y < drop_ref). Then y ← floor_y, state ← GROUND, landed=1, drop_act ← 0.
  - Floor-ignore: if drop_act=1 and floor_y ≥ drop_ref, the floor is ignored.
  - Below zero: if y_n < 0, then y ← 0 and landing is forced regardless of drop_act.
  - Otherwise y ← y_n.
- In AIR, a drop request or a jump with jumps_left=0 is discarded.

## Timing
- Reset (reset=0 at a clk edge):
  - y=RESET_Y, vel=0, state=GROUND, pend=0, drop_act=0, jumps_left=0.
  - Outputs: yout=RESET_Y, airborne=0, landed=0, busy_op=0.
  - Reset wins over `update` and `operation` on the same edge. Reset mid-jump returns to GROUND at RESET_Y immediately.
- `yout`, `airborne` and `landed` are registered. They reflect a tick on the cycle after the edge that sampled `update`=1.
- A request on the same cycle as `update` is captured into `pend` on that edge. It is not used until the following tick, which gives one tick of request latency.
- `landed` is high for exactly one clk cycle per touchdown.

## Test plan
- Big jump, with floor_y=20 and defaults:
  - Stimulus: op 001, then ticks.
  - Launch tick: y stays 20, airborne=1.
  - Next ticks: yout = 29, 37, 44, 50, 55, 59, 62, 64, 65, 65, 64, 62, 59, 55, 50, 44, 37, 29, 21, 20.
  - `landed` pulses after the 20 = floor.
- Small jump, with floor_y=20: yout = 27, 33, 38, 42, 45, 47, 48, 48, 47, 45, 42, 38, 33, 27, 20; landed on the last value.
- Ceiling, with RESET_Y=floor_y=120 and a big jump: yout = 127 (clamped, vel→0), then 127, 126, 124, …; lands at 120.
- Drop-through:
  - Setup: at y=60 with floor_y=60, issue op 100. Hold floor_y=60 for 3 ticks, then floor_y=30.
  - Expected: yout = 59, 57, 54, then continues falling; lands at 30, not at 60.
- Walk-off: in GROUND at 60, floor_y→40 → airborne. yout = 60, 59, 57, 54, 50, 45, 40 with landed.
- Double jump:
  - With DOUBLE_JUMP=1: small jump, then a second op 010 at apex 48 resets vel to 7 (y stays 48, then 55, …). A third request is ignored; busy_op clears after the next tick.
  - With DOUBLE_JUMP=0: the second request has no effect.
  - Reset asserted mid-air → yout=20 and airborne=0 next cycle.
